// File: rtl/window_fifo_sched_pkg.sv
// ============================================================================
// Module   : window_fifo_sched_pkg
// Brief    : Shared state encoding and width helpers for window_fifo_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package window_fifo_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } wfs_state_t;

   localparam int DEF_DEPTH     = 256 * 256;
   localparam int DEF_FRAME_LEN = 256 * 256;

   // floor(log2(v)) for v >= 1
   function automatic int flog2(input int v);
      int r;
      r = 0;
      for (int i = 1; i < 31; i++) begin
         if (v >= (1 << i)) r = i;
      end
      return r;
   endfunction

   // Counter width large enough to hold both the occupancy and the frame count
   function automatic int cw_of(input int depth, input int frame_len);
      return flog2((depth > frame_len) ? depth : frame_len) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/window_fifo_sched_if.sv
// ============================================================================
// Module   : window_fifo_sched_if
// Brief    : Producer/consumer/FIFO handshake bundle of the window scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface window_fifo_sched_if;

   logic s_valid;
   logic s_ready;
   logic m_req;
   logic m_valid;
   logic fifo_write;
   logic fifo_read;
   logic fifo_full;
   logic fifo_out_verify;

   modport slave (
      input  s_valid,
      input  m_req,
      input  fifo_full,
      input  fifo_out_verify,
      output s_ready,
      output m_valid,
      output fifo_write,
      output fifo_read
   );

   modport master (
      output s_valid,
      output m_req,
      output fifo_full,
      output fifo_out_verify,
      input  s_ready,
      input  m_valid,
      input  fifo_write,
      input  fifo_read
   );

endinterface

`default_nettype wire

// File: rtl/wfs_rr_arb2.sv
// ============================================================================
// Module   : wfs_rr_arb2
// Brief    : Two-requester round-robin arbiter (write vs read) with a
//            last-grant flag that only moves on contended cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wfs_rr_arb2 (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic i_req_wr,
   input  wire logic i_req_rd,
   output logic      o_gnt_wr,
   output logic      o_gnt_rd
);

   // 1 = write won the most recent contended cycle; cleared so write wins first
   logic r_last_wr;
   logic w_contend;

   assign w_contend = i_req_wr & i_req_rd;

   always_comb begin
      o_gnt_wr = 1'b0;
      o_gnt_rd = 1'b0;
      if (w_contend) begin
         o_gnt_wr = ~r_last_wr;
         o_gnt_rd =  r_last_wr;
      end else begin
         o_gnt_wr = i_req_wr;
         o_gnt_rd = i_req_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last_wr <= 1'b0;
      end else if (w_contend) begin
         r_last_wr <= ~r_last_wr;
      end
   end

endmodule

`default_nettype wire

// File: rtl/window_fifo_sched.sv
// ============================================================================
// Module   : window_fifo_sched
// Brief    : Frame sequencer and single-op-per-cycle write/read scheduler for
//            the convolution window FIFO. Error checks are built only when
//            WINDOW_FIFO_SCHED_ERR_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_fifo_sched
   import window_fifo_sched_pkg::*;
#(
   parameter  int DEPTH     = DEF_DEPTH,
   parameter  int FRAME_LEN = DEF_FRAME_LEN,
   localparam int CW        = cw_of(DEPTH, FRAME_LEN)
) (
   input  wire logic           clk,
   input  wire logic           reset,
   input  wire logic           i_start,
   window_fifo_sched_if.slave  bus,
   output logic [CW-1:0]       o_level,
   output logic                o_busy,
   output logic                o_frame_done,
   output logic                o_err
);

   localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
   localparam logic [CW-1:0] c_frame_len = CW'(FRAME_LEN);
   localparam logic [CW-1:0] c_zero      = '0;
   localparam logic [CW-1:0] c_one       = CW'(1);

   wfs_state_t    r_state;
   logic [CW-1:0] r_level;
   logic [CW-1:0] r_wr_cnt;
   logic [CW-1:0] r_rd_cnt;
   logic          r_m_valid;
   logic          r_busy;
   logic          r_frame_done;

   logic          w_wr_elig;
   logic          w_rd_elig;
   logic          w_gnt_wr;
   logic          w_gnt_rd;
   logic [CW-1:0] w_level_inc;
   logic [CW-1:0] w_level_dec;

   assign w_wr_elig = (r_state == ST_RUN) && bus.s_valid &&
                      (r_level < c_depth) && (r_wr_cnt < c_frame_len);

   assign w_rd_elig = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && bus.m_req &&
                      (r_level > c_zero) && (r_rd_cnt < c_frame_len);

   wfs_rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_req_wr (w_wr_elig),
      .i_req_rd (w_rd_elig),
      .o_gnt_wr (w_gnt_wr),
      .o_gnt_rd (w_gnt_rd)
   );

   assign w_level_inc = w_gnt_wr ? c_one : c_zero;
   assign w_level_dec = w_gnt_rd ? c_one : c_zero;

   // Frame sequencing, occupancy and counters share one clocked process
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_level      <= c_zero;
         r_wr_cnt     <= c_zero;
         r_rd_cnt     <= c_zero;
         r_m_valid    <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_m_valid <= w_gnt_rd;
         r_level   <= r_level + w_level_inc - w_level_dec;
         if (w_gnt_wr) r_wr_cnt <= r_wr_cnt + c_one;
         if (w_gnt_rd) r_rd_cnt <= r_rd_cnt + c_one;

         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state  <= ST_RUN;
                  r_busy   <= 1'b1;
                  r_wr_cnt <= c_zero;
                  r_rd_cnt <= c_zero;
               end
            end
            ST_RUN: begin
               if (r_wr_cnt == c_frame_len) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // last read must have returned: no grant may still be outstanding
               if ((r_rd_cnt == c_frame_len) && !w_gnt_rd) begin
                  r_state      <= ST_DONE;
                  r_frame_done <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s_ready    = w_gnt_wr;
   assign bus.fifo_write = w_gnt_wr;
   assign bus.fifo_read  = w_gnt_rd;
   assign bus.m_valid    = r_m_valid;

   assign o_level      = r_level;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;

`ifdef WINDOW_FIFO_SCHED_ERR_CHECK_EN
   logic r_err;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (bus.fifo_full || (r_m_valid && !bus.fifo_out_verify)) begin
         r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`else
   logic w_unused_err_inputs;

   assign w_unused_err_inputs = bus.fifo_full ^ bus.fifo_out_verify;
   assign o_err               = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_window_fifo_sched.sv
// ============================================================================
// Module   : tb_window_fifo_sched
// Brief    : Randomized self-checking bench for window_fifo_sched against a
//            counter/phase reference model (DEPTH=4, FRAME_LEN=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_fifo_sched;
   import window_fifo_sched_pkg::*;

   localparam int D  = 4;
   localparam int F  = 8;
   localparam int CW = cw_of(D, F);
`ifdef WINDOW_FIFO_SCHED_ERR_CHECK_EN
   localparam int ERR_ON = 1;
`else
   localparam int ERR_ON = 0;
`endif

   logic          clk;
   logic          reset;
   logic          start;
   logic [CW-1:0] level;
   logic          busy;
   logic          frame_done;
   logic          err;

   window_fifo_sched_if bus ();

   window_fifo_sched #(.DEPTH(D), .FRAME_LEN(F)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (start),
      .bus          (bus.slave),
      .o_level      (level),
      .o_busy       (busy),
      .o_frame_done (frame_done),
      .o_err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: phase 0 idle, 1 run, 2 drain, 3 done
   int m_ph, m_wr, m_rd, m_lvl, m_mv, m_last_w, m_err;
   int cyc, n_wr, n_rd, n_done, n_both, last_mv_cyc, done_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_wr = 0; m_rd = 0; m_lvl = 0; m_mv = 0; m_last_w = 0; m_err = 0;
   endtask

   task automatic clr_stats();
      n_wr = 0; n_rd = 0; n_done = 0; n_both = 0; last_mv_cyc = -1; done_cyc = -1;
   endtask

   // One clock cycle: drive, check mid-cycle against the model, advance model
   task automatic cycle(input logic st, input logic sv, input logic mr,
                        input logic ff, input logic ov, input logic rn);
      int we, re, gw, gr, old_ph, old_wr, old_rd, old_mv;
      reset = rn; start = st;
      bus.s_valid = sv; bus.m_req = mr; bus.fifo_full = ff; bus.fifo_out_verify = ov;
      #2;
      we = (m_ph == 1 && sv && m_lvl < D && m_wr < F) ? 1 : 0;
      re = ((m_ph == 1 || m_ph == 2) && mr && m_lvl > 0 && m_rd < F) ? 1 : 0;
      gw = (we && (!re || !m_last_w)) ? 1 : 0;
      gr = (re && (!we || m_last_w)) ? 1 : 0;
      chk("s_ready",    bus.s_ready,    gw);
      chk("fifo_write", bus.fifo_write, gw);
      chk("fifo_read",  bus.fifo_read,  gr);
      chk("m_valid",    bus.m_valid,    m_mv);
      chk("level",      level,          m_lvl);
      chk("busy",       busy,           (m_ph != 0) ? 1 : 0);
      chk("frame_done", frame_done,     (m_ph == 3) ? 1 : 0);
      chk("err",        err,            m_err);
      if (bus.fifo_write) n_wr++;
      if (bus.fifo_read)  n_rd++;
      if (bus.fifo_write && bus.fifo_read) n_both++;
      if (bus.m_valid) last_mv_cyc = cyc;
      if (frame_done) begin n_done++; done_cyc = cyc; end
      @(posedge clk);
      if (!rn) begin
         model_reset();
      end else begin
         old_ph = m_ph; old_wr = m_wr; old_rd = m_rd; old_mv = m_mv;
         if (we && re) m_last_w = gw;
         m_mv  = gr;
         m_lvl = m_lvl + gw - gr;
         m_wr  = m_wr + gw;
         m_rd  = m_rd + gr;
         case (old_ph)
            0: if (st) begin m_ph = 1; m_wr = 0; m_rd = 0; end
            1: if (old_wr == F) m_ph = 2;
            2: if (old_rd == F && !gr) m_ph = 3;
            default: m_ph = 0;
         endcase
         if (ERR_ON != 0 && (ff || (old_mv && !ov))) m_err = 1;
      end
      cyc++;
      #1;
   endtask

   function automatic logic pct(input int p);
      return ($urandom_range(0, 99) < p) ? 1'b1 : 1'b0;
   endfunction

   // Run cycles until the model returns to idle, bounded
   task automatic finish_frame(input int sv_pct, input int mr_pct, input int st_pct, input string tag);
      int k;
      k = 0;
      while (m_ph != 0 && k < 400) begin
         cycle(pct(st_pct), pct(sv_pct), pct(mr_pct), 1'b0, 1'b1, 1'b1);
         k++;
      end
      chk({tag, "_timeout"}, m_ph, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      cyc = 0;
      model_reset();
      clr_stats();
      reset = 1'b0; start = 1'b0;
      bus.s_valid = 1'b0; bus.m_req = 1'b0; bus.fifo_full = 1'b0; bus.fifo_out_verify = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      cycle(0, 1, 1, 0, 1, 0);
      chk("rst_level", level, 0);
      chk("rst_busy", busy, 0);

      // fill: producer only, consumer stalled
      clr_stats();
      cycle(1, 1, 0, 0, 1, 1);
      repeat (10) cycle(0, 1, 0, 0, 1, 1);
      chk("fill_writes", n_wr, D);
      chk("fill_level", level, D);
      chk("fill_ready_held", bus.s_ready, 0);
      chk("fill_err", err, 0);
      finish_frame(100, 100, 0, "fill_drain");

      // continuous contention from a fresh arbiter state
      cycle(0, 0, 0, 0, 1, 0);
      clr_stats();
      s = cyc;
      cycle(1, 1, 1, 0, 1, 1);
      finish_frame(100, 100, 0, "cont");
      chk("cont_writes", n_wr, F);
      chk("cont_reads", n_rd, F);
      chk("cont_both", n_both, 0);
      chk("cont_frame_time", cyc - s, 2 * F + 3);
      chk("cont_done_after_mv", done_cyc - last_mv_cyc, 1);
      chk("cont_done_count", n_done, 1);
      chk("cont_idle", busy, 0);

      // empty FIFO with consumer requesting, then one write followed by a read
      clr_stats();
      cycle(1, 0, 1, 0, 1, 1);
      repeat (4) cycle(0, 0, 1, 0, 1, 1);
      chk("empty_no_read", n_rd, 0);
      cycle(0, 1, 1, 0, 1, 1);
      chk("empty_one_write", n_wr, 1);
      cycle(0, 0, 1, 0, 1, 1);
      chk("empty_read_next", n_rd, 1);
      finish_frame(80, 80, 0, "empty");

      // start pulses during a frame are ignored
      clr_stats();
      cycle(1, 1, 1, 0, 1, 1);
      finish_frame(60, 60, 50, "restart");
      chk("restart_writes", n_wr, F);
      chk("restart_done_count", n_done, 1);

      // reset mid-frame after 3 writes and 1 read
      clr_stats();
      cycle(1, 0, 0, 0, 1, 1);
      repeat (3) cycle(0, 1, 0, 0, 1, 1);
      cycle(0, 0, 1, 0, 1, 1);
      chk("mid_writes", n_wr, 3);
      chk("mid_reads", n_rd, 1);
      cycle(0, 0, 0, 0, 1, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_mvalid", bus.m_valid, 0);
      chk("mid_rst_busy", busy, 0);
      clr_stats();
      cycle(1, 1, 1, 0, 1, 1);
      finish_frame(70, 70, 0, "mid_clean");
      chk("mid_clean_writes", n_wr, F);
      chk("mid_clean_reads", n_rd, F);

      // randomized frames
      for (int f = 0; f < 12; f++) begin
         clr_stats();
         cycle(1, pct(50), pct(50), 1'b0, 1'b1, 1'b1);
         finish_frame($urandom_range(20, 95), $urandom_range(20, 95), 15, "rand");
         chk("rand_writes", n_wr, F);
         chk("rand_reads", n_rd, F);
         chk("rand_done_after_mv", done_cyc - last_mv_cyc, 1);
         repeat ($urandom_range(0, 3)) cycle(0, pct(50), pct(50), 1'b0, 1'b1, 1'b1);
      end

      // error reporting: full flag pulse, then bad verify on a returned read
      cycle(0, 0, 0, 1, 1, 1);
      cycle(0, 0, 0, 0, 1, 1);
      chk("err_full_sticky", err, ERR_ON);
      cycle(0, 0, 0, 0, 1, 0);
      chk("err_cleared", err, 0);
      cycle(1, 1, 0, 0, 1, 1);
      cycle(0, 1, 0, 0, 1, 1);
      cycle(0, 0, 1, 0, 1, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1, 1);
      chk("err_verify", err, ERR_ON);
      cycle(0, 0, 0, 0, 1, 0);
      chk("err_final_clear", err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
